// File: rtl/result_writer.sv
// result_writer: scripted bus master for the data-memory write port.
// Emits one marker write to BASE_ADDR, then up to DEPTH result words from a
// loadable table to consecutive word addresses. Each write is held while
// stall=1, and GAP wen-low cycles separate writes so the checker counts each
// write once.
module result_writer #(
  parameter int          DEPTH     = 8,
  parameter logic [29:0] BASE_ADDR = 30'h0,
  parameter logic [31:0] MARKER    = 32'h00000005,
  parameter int          GAP       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  num,
  input  logic        stall,
  input  logic        load_en,
  input  logic [3:0]  load_idx,
  input  logic [31:0] load_data,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done,
  output logic [4:0]  wr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

  localparam logic [4:0]    DEPTH_N  = 5'(DEPTH);
  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  // Storage is rounded up to a power of two so idx slices index it directly;
  // entries at or above DEPTH are never loaded and stay zero.
  logic [31:0] tbl [2**IW];

  state_t        state, state_d;
  logic [29:0]   addr_d;
  logic [31:0]   data_d;
  logic          wen_d, busy_d, done_d;
  logic [4:0]    wr_cnt_d;
  logic [4:0]    n_q, n_d;        // result writes in the running sequence
  logic [4:0]    idx_q, idx_d;    // next table entry to drive
  logic [GW-1:0] gap_q, gap_d;    // remaining wen-low cycles minus one
  logic [4:0]    n_clamp;
  logic          load_ok;

  assign n_clamp = (num > DEPTH_N) ? DEPTH_N : num;
  assign load_ok = load_en && !busy && ({1'b0, load_idx} < DEPTH_N);

  // Next-state and next-output logic for the write sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d  = state;
    addr_d   = addr;
    data_d   = data;
    wen_d    = wen;
    busy_d   = busy;
    done_d   = done;
    wr_cnt_d = wr_cnt;
    n_d      = n_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_WRITE;
          n_d      = n_clamp;
          idx_d    = '0;
          wr_cnt_d = '0;
          addr_d   = BASE_ADDR;
          data_d   = MARKER;
          wen_d    = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      S_WRITE: begin
        // A stalled write keeps addr/data/wen exactly as they are.
        if (!stall) begin
          wr_cnt_d = wr_cnt + 5'd1;
          wen_d    = 1'b0;
          if (wr_cnt == n_q) begin
            // Marker plus n results have now been accepted.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_WRITE;
          wen_d   = 1'b1;
          addr_d  = BASE_ADDR + 30'(idx_q) + 30'd1;  // wraps modulo 2^30
          data_d  = tbl[idx_q[IW-1:0]];
          idx_d   = idx_q + 5'd1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered bus outputs; rst aborts any sequence at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      data   <= '0;
      wen    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_cnt <= '0;
      n_q    <= '0;
      idx_q  <= '0;
      gap_q  <= '0;
    end else begin
      state  <= state_d;
      addr   <= addr_d;
      data   <= data_d;
      wen    <= wen_d;
      busy   <= busy_d;
      done   <= done_d;
      wr_cnt <= wr_cnt_d;
      n_q    <= n_d;
      idx_q  <= idx_d;
      gap_q  <= gap_d;
    end
  end

  // Result table: loads are blocked while busy so a running sequence sees a
  // frozen table.
  always_ff @(posedge clk) begin
    // NOTE: the table is a small register file, not RAM, and is cleared on
    // reset so a run after rst emits deterministic zeros.
    if (rst) begin
      for (int i = 0; i < 2**IW; i++) tbl[i] <= '0;
    end else if (load_ok) begin
      tbl[load_idx[IW-1:0]] <= load_data;
    end
  end

endmodule

// File: doc/result_writer.md
# result_writer

Bus-master sequencer that drives the data-memory write port (addr, data, wen) with a scripted stream of result words, exactly the traffic the end-of-run result checker expects from the CPU. It issues one marker write to the base test port followed by up to DEPTH result writes to consecutive word addresses. Each write is held stable through a D-cache-style stall, and wen is dropped between writes so the checker counts each write once. It replaces the CPU on the write port for checker bring-up and for regression of the checker itself.

## Interface
Clock and reset:
- One clock: clk.
- Reset: rst, synchronous, active-high.

Parameters:
- DEPTH, 8: result table entries, 1..16.
- BASE_ADDR, 30'h0: word address of the marker write; result i goes to BASE_ADDR+1+i.
- MARKER, 32'h00000005: data of the marker write.
- GAP, 1: wen-low cycles between writes, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that launches a sequence; honoured only in IDLE or DONE.
- num  in  5  number of result writes, sampled with start; values > DEPTH are clamped to DEPTH.
- stall  in  1  write not accepted this cycle; hold outputs.
- load_en  in  1  table write strobe; honoured only when busy=0.
- load_idx  in  4  table index; indices ≥ DEPTH are ignored.
- load_data  in  32  table entry value.
- addr  out  30  write word address (registered).
- data  out  32  write data (registered).
- wen  out  1  write enable (registered).
- busy  out  1  high from the cycle after an accepted start until the last write is accepted.
- done  out  1  high in the DONE state.
- wr_cnt  out  5  accepted writes in the current sequence, including the marker.

## Operation
- Table: DEPTH×32 registers, cleared to 0 on rst; written when load_en=1 and busy=0.
- Accepted write: a cycle with wen=1 and stall=0.
- States:
  - IDLE: outputs quiet.
  - WRITE: wen=1 with addr/data valid.
  - GAP: wen=0, GAP-cycle counter.
  - DONE: done=1.
- Transitions:
  - IDLE/DONE + start → WRITE. Latch n=min(num,DEPTH), idx=0, wr_cnt=0. Drive addr=BASE_ADDR, data=MARKER; done clears.
  - WRITE, stall=1 → stay in WRITE; addr/data/wen unchanged.
  - WRITE, accepted → wr_cnt+1. If this was write number n+1 (marker plus n results) → DONE. Otherwise → GAP.
  - GAP → after GAP cycles go to WRITE with addr=BASE_ADDR+1+idx, data=table[idx]; idx+1.
  - DONE: hold until start (restart) or rst.
- start while busy is ignored, and num is not re-sampled.
- stall is ignored outside WRITE.
- addr is computed modulo 2^30; wrap past 30'h3FFFFFFF is permitted and silent.
- Table updates after start never affect entries already driven. Loads are blocked while busy=1, so the running sequence sees a frozen table.

## Timing
- Reset (cycle after rst=1): addr=0, data=0, wen=0, busy=0, done=0, wr_cnt=0, state IDLE. rst mid-sequence aborts the sequence immediately, and wen is 0 the next cycle.
- start sampled at edge T → wen=1, busy=1 from T+1.
- Write accepted at A:
  - wen=0 in A+1..A+GAP.
  - Next write visible at A+GAP+1.
  - wr_cnt increments at A+1.
- Last write accepted at A → done=1, busy=0, wen=0 at A+1.
- No-stall sequence length: (n+1) writes plus n·GAP gap cycles from the first wen until the last accept.
- start and stall in the same IDLE cycle: stall is ignored and start proceeds.
- start in the same cycle as rst: rst wins.
- load_en in the same cycle as start (busy=0): the load is honoured, and the entry is used if its index is ≥ the current idx when driven.

## Test plan
- Load table {4,4,4}, start with num=3, stall=0, GAP=1 → writes (0,5), (1,4), (2,4), (3,4), each with one wen-high cycle separated by one wen-low cycle. done=1 and wr_cnt=4 at the cycle after the 4th accept. The result checker reports 0 errors.
- Same stream with stall=1 for 3 cycles during write (2,4) → addr=2, data=4, wen=1 held for 4 cycles; exactly one accept; wr_cnt ends at 4.
- num=0 → single write (0,5); done=1 two cycles after start; wr_cnt=1. num=20 with DEPTH=8 → 9 writes, the last to addr 8.
- start pulse and load_en (idx 1, value 7) issued mid-sequence → both ignored. The stream is unchanged, and table[1] still reads back as 4 on the next run.
- rst asserted while wen=1 on write (2,4) → next cycle wen=0, busy=0, done=0, wr_cnt=0, table cleared. A following start with num=3 emits (0,5), (1,0), (2,0), (3,0).
- After DONE, start again with num=2 → done drops at T+1 and writes (0,5), (1,4), (2,4) repeat; wr_cnt restarts from 0.
